pi_cmd_queue: RTL and testbench

PI_CMD_QUEUE -- requirements
Module: pi_cmd_queue

---
 rtl/pistorm_pkg.sv | 54 +++++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/pi_cmd_queue.sv | 231 +++++++++++++++++++++++
 tb/tb_pi_cmd_queue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pistorm_pkg.sv
// ---------------------------------------------------------------------------
// pistorm_pkg
// Shared definitions for the Pi-side command path of the 68k bus bridge:
//   - REG_* : Pi register-select codes presented on pi_a
//   - cmd_entry_t : one queued bus command, strobes already resolved
//   - issue_state_e : states of the command issue FSM
//   - make_entry() : builds a queue entry from the staged Pi writes
// ---------------------------------------------------------------------------
package pistorm_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } cmd_entry_t;

  localparam int CMD_ENTRY_W = $bits(cmd_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } issue_state_e;

  // Strobes are resolved when the entry is built so the issue side only has
  // to copy fields. A word access drives both strobes; a byte access picks
  // the upper lane for even addresses and the lower lane for odd ones.
  function automatic cmd_entry_t make_entry(input logic [7:0]  addr_hi,
                                            input logic        is_byte,
                                            input logic        rw,
                                            input logic [15:0] addr_lo,
                                            input logic [15:0] wdata);
    cmd_entry_t e;
    e.addr  = {addr_hi, addr_lo};
    e.wdata = wdata;
    e.rw    = rw;
    if (is_byte) begin
      e.uds_n = addr_lo[0];
      e.lds_n = ~addr_lo[0];
    end else begin
      e.uds_n = 1'b0;
      e.lds_n = 1'b0;
    end
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is visible on rdata whenever
// empty is low, so a consumer can pop and use the data on the same edge.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, wdata     write request and data (ignored when full unless popping)
//   pop             remove the head entry (ignored when empty)
//   rdata           current head entry
//   full, empty     occupancy flags
//   count           number of stored entries, width log2(DEPTH)+1
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves on the
  // same edge, which keeps the occupancy constant.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pi_cmd_queue.sv
// ---------------------------------------------------------------------------
// pi_cmd_queue
// Collects register writes from the Raspberry Pi into 68k bus commands,
// queues them, and hands them one at a time to the bus sequencer.
// Pi side:
//   c200m, rst        system clock, synchronous active-high reset
//   pi_a              register select (DATA / ADDR_LO / ADDR_HI / STATUS)
//   pi_wdata          write data; an ADDR_HI write pushes a command
//   pi_wr_stb         one-cycle write pulse
//   pi_rd_stb         one-cycle read pulse; pi_rdata updates one cycle later
//   pi_rdata          registered read-back
//   txn_in_progress   tells the Pi to hold off
//   q_full            command FIFO full
// Sequencer side:
//   op_req            request, held until op_ack
//   op_addr/op_wdata  address and write data, stable for the whole cycle
//   op_rw             1 = read
//   op_uds_n/op_lds_n data strobes, active low
//   op_ack            request accepted
//   op_done           bus cycle finished, op_rdata valid
// Build option: PI_CMD_QUEUE_POSTED_WR_EN makes writes posted, so the Pi is
// only held off for a full queue or for outstanding reads.
// ---------------------------------------------------------------------------
module pi_cmd_queue
  import pistorm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        c200m,
  input  logic        rst,
  input  logic [1:0]  pi_a,
  input  logic [15:0] pi_wdata,
  input  logic        pi_wr_stb,
  input  logic        pi_rd_stb,
  output logic [15:0] pi_rdata,
  output logic        txn_in_progress,
  output logic        q_full,
  output logic        op_req,
  output logic [23:0] op_addr,
  output logic [15:0] op_wdata,
  output logic        op_rw,
  output logic        op_uds_n,
  output logic        op_lds_n,
  input  logic        op_ack,
  input  logic        op_done,
  input  logic [15:0] op_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]            addr_lo_q;
  logic [15:0]            wdata_q;
  logic [15:0]            rdata_reg_q;
  logic [15:0]            pi_rdata_q;
  logic                   overflow_q;
  issue_state_e           state_q;
  logic                   op_req_q;
  logic [23:0]            op_addr_q;
  logic [15:0]            op_wdata_q;
  logic                   op_rw_q;
  logic                   op_uds_n_q;
  logic                   op_lds_n_q;

  logic                   push_req;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [CMD_ENTRY_W-1:0] fifo_wdata;
  logic [CMD_ENTRY_W-1:0] fifo_rdata;
  cmd_entry_t             push_entry;
  cmd_entry_t             head_entry;
  logic                   fsm_busy;
  logic                   push_dropped;
  logic [3:0]             count_nib;
  logic [15:0]            status_word;

  assign push_req   = pi_wr_stb && (pi_a == REG_ADDR_HI);
  assign push_entry = make_entry(pi_wdata[7:0], pi_wdata[8], pi_wdata[9],
                                 addr_lo_q, wdata_q);
  assign fifo_wdata = push_entry;
  assign head_entry = cmd_entry_t'(fifo_rdata);

  // The FSM takes the head entry on the same edge it leaves IDLE.
  assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty;
  assign fsm_busy     = (state_q != ST_IDLE);
  assign push_dropped = push_req && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (CMD_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (c200m),
    .rst   (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign count_nib   = 4'(fifo_count);
  assign status_word = {overflow_q, fifo_full, fifo_empty, fsm_busy,
                        count_nib, 8'd0};

  // Staging registers: the low address half and the write data are held
  // here until the ADDR_HI write turns them into a queue entry.
  always_ff @(posedge c200m) begin
    if (rst) begin
      addr_lo_q <= '0;
      wdata_q   <= '0;
    end else if (pi_wr_stb) begin
      if (pi_a == REG_ADDR_LO) addr_lo_q <= pi_wdata;
      if (pi_a == REG_DATA)    wdata_q   <= pi_wdata;
    end
  end

  // Sticky overflow; a dropped push on the same cycle as a STATUS read
  // keeps the flag set so the event is never lost.
  always_ff @(posedge c200m) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (push_dropped) begin
      overflow_q <= 1'b1;
    end else if (pi_rd_stb && (pi_a == REG_STATUS)) begin
      overflow_q <= 1'b0;
    end
  end

  // Registered Pi read-back, captured on the read strobe.
  always_ff @(posedge c200m) begin
    if (rst) begin
      pi_rdata_q <= '0;
    end else if (pi_rd_stb) begin
      case (pi_a)
        REG_DATA:   pi_rdata_q <= rdata_reg_q;
        REG_STATUS: pi_rdata_q <= status_word;
        default:    pi_rdata_q <= '0;
      endcase
    end
  end

  // Issue FSM. The op_* registers are only loaded when leaving IDLE, so
  // they stay put for the whole REQ/WAIT span. Acknowledge and completion
  // on the same cycle skip WAIT entirely.
  always_ff @(posedge c200m) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_req_q    <= 1'b0;
      op_addr_q   <= '0;
      op_wdata_q  <= '0;
      op_rw_q     <= 1'b1;
      op_uds_n_q  <= 1'b1;
      op_lds_n_q  <= 1'b1;
      rdata_reg_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op_addr_q  <= head_entry.addr;
            op_wdata_q <= head_entry.wdata;
            op_rw_q    <= head_entry.rw;
            op_uds_n_q <= head_entry.uds_n;
            op_lds_n_q <= head_entry.lds_n;
            op_req_q   <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (op_ack) begin
            op_req_q <= 1'b0;
            if (op_done) begin
              state_q <= ST_IDLE;
              if (op_rw_q) rdata_reg_q <= op_rdata;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (op_done) begin
            state_q <= ST_IDLE;
            if (op_rw_q) rdata_reg_q <= op_rdata;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          op_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PI_CMD_QUEUE_POSTED_WR_EN
  logic [CW-1:0] reads_queued_q;
  logic          push_accepted;

  assign push_accepted = push_req && (!fifo_full || fifo_pop);

  // Tracks how many read entries are still waiting in the FIFO, since only
  // reads need to hold the Pi off once writes are posted.
  always_ff @(posedge c200m) begin
    if (rst) begin
      reads_queued_q <= '0;
    end else begin
      case ({push_accepted && push_entry.rw, fifo_pop && head_entry.rw})
        2'b10:   reads_queued_q <= reads_queued_q + 1'b1;
        2'b01:   reads_queued_q <= reads_queued_q - 1'b1;
        default: reads_queued_q <= reads_queued_q;
      endcase
    end
  end

  assign txn_in_progress = fifo_full || (fsm_busy && op_rw_q) ||
                           (reads_queued_q != '0);
`else
  assign txn_in_progress = fsm_busy || !fifo_empty;
`endif

  assign pi_rdata = pi_rdata_q;
  assign q_full   = fifo_full;
  assign op_req   = op_req_q;
  assign op_addr  = op_addr_q;
  assign op_wdata = op_wdata_q;
  assign op_rw    = op_rw_q;
  assign op_uds_n = op_uds_n_q;
  assign op_lds_n = op_lds_n_q;

endmodule

// File: tb/tb_pi_cmd_queue.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pi_cmd_queue
// Drives Pi register writes/reads and plays the bus sequencer. Every command
// pushed through the Pi registers is also pushed to a scoreboard queue with
// its expected bus fields; a monitor pops and compares on each op_req rise.
// ---------------------------------------------------------------------------
module tb_pi_cmd_queue;

  localparam int DEPTH = 4;
`ifdef PI_CMD_QUEUE_POSTED_WR_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  logic        c200m = 1'b0;
  logic        rst;
  logic [1:0]  pi_a;
  logic [15:0] pi_wdata;
  logic        pi_wr_stb;
  logic        pi_rd_stb;
  logic [15:0] pi_rdata;
  logic        txn_in_progress;
  logic        q_full;
  logic        op_req;
  logic [23:0] op_addr;
  logic [15:0] op_wdata;
  logic        op_rw;
  logic        op_uds_n;
  logic        op_lds_n;
  logic        op_ack;
  logic        op_done;
  logic [15:0] op_rdata;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } expCmd_t;

  expCmd_t opQueue[$];
  expCmd_t curCmd;
  logic    reqSeen = 1'b0;
  int      checkCount = 0;
  int      errorCount = 0;

  pi_cmd_queue #(.DEPTH(DEPTH)) dut (
    .c200m           (c200m),
    .rst             (rst),
    .pi_a            (pi_a),
    .pi_wdata        (pi_wdata),
    .pi_wr_stb       (pi_wr_stb),
    .pi_rd_stb       (pi_rd_stb),
    .pi_rdata        (pi_rdata),
    .txn_in_progress (txn_in_progress),
    .q_full          (q_full),
    .op_req          (op_req),
    .op_addr         (op_addr),
    .op_wdata        (op_wdata),
    .op_rw           (op_rw),
    .op_uds_n        (op_uds_n),
    .op_lds_n        (op_lds_n),
    .op_ack          (op_ack),
    .op_done         (op_done),
    .op_rdata        (op_rdata)
  );

  // 200 MHz system clock
  always #2.5 c200m = ~c200m;

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic expCmd_t modelCmd(input logic [23:0] addr, input logic [15:0] data,
                                       input logic isByte, input logic rw);
    expCmd_t c;
    c.addr  = addr;
    c.wdata = data;
    c.rw    = rw;
    c.uds_n = isByte ? addr[0] : 1'b0;
    c.lds_n = isByte ? ~addr[0] : 1'b0;
    return c;
  endfunction

  // Monitor: each new bus request is compared to the oldest expected command
  always @(negedge c200m) begin
    if (op_req && !reqSeen) begin
      if (opQueue.size() == 0) begin
        checkOutput("unexpected_req", 32'd1, 32'd0);
      end else begin
        curCmd = opQueue.pop_front();
        checkOutput("op_addr",  32'(op_addr),  32'(curCmd.addr));
        checkOutput("op_wdata", 32'(op_wdata), 32'(curCmd.wdata));
        checkOutput("op_rw",    32'(op_rw),    32'(curCmd.rw));
        checkOutput("op_uds_n", 32'(op_uds_n), 32'(curCmd.uds_n));
        checkOutput("op_lds_n", 32'(op_lds_n), 32'(curCmd.lds_n));
      end
    end
    reqSeen = op_req;
  end

  // All Pi tasks start and end just after a falling edge
  task automatic piWrite(input logic [1:0] a, input logic [15:0] d);
    pi_a      = a;
    pi_wdata  = d;
    pi_wr_stb = 1'b1;
    @(negedge c200m);
    pi_wr_stb = 1'b0;
  endtask

  task automatic piRead(input logic [1:0] a, output logic [15:0] d);
    pi_a      = a;
    pi_rd_stb = 1'b1;
    @(negedge c200m);
    pi_rd_stb = 1'b0;
    d = pi_rdata;
  endtask

  task automatic checkRead(input string tag, input logic [1:0] a, input logic [15:0] expected);
    logic [15:0] d;
    piRead(a, d);
    checkOutput(tag, 32'(d), 32'(expected));
  endtask

  // Full command through the Pi registers; accepted commands go to the scoreboard
  task automatic applyStimulus(input logic [23:0] addr, input logic [15:0] data,
                               input logic isByte, input logic rw, input logic accepted);
    piWrite(2'd1, addr[15:0]);
    piWrite(2'd0, data);
    if (accepted) opQueue.push_back(modelCmd(addr, data, isByte, rw));
    piWrite(2'd2, {6'd0, rw, isByte, addr[23:16]});
  endtask

  task automatic waitReq(input int budget);
    int n = 0;
    while (!op_req && n < budget) begin
      @(negedge c200m);
      n++;
    end
    checkOutput("req_within_budget", 32'(op_req), 32'd1);
  endtask

  // Sequencer: acknowledge, then complete one cycle later
  task automatic serveCmd(input logic [15:0] rdata);
    waitReq(4);
    op_ack = 1'b1;
    @(negedge c200m);
    op_ack = 1'b0;
    checkOutput("req_dropped_after_ack", 32'(op_req), 32'd0);
    checkOutput("op_addr_stable", 32'(op_addr), 32'(curCmd.addr));
    op_done  = 1'b1;
    op_rdata = rdata;
    @(negedge c200m);
    op_done  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    pi_a      = 2'd0;
    pi_wdata  = '0;
    pi_wr_stb = 1'b0;
    pi_rd_stb = 1'b0;
    op_ack    = 1'b0;
    op_done   = 1'b0;
    op_rdata  = '0;
    repeat (3) @(negedge c200m);

    // Reset state
    checkOutput("rst_op_req",   32'(op_req),   32'd0);
    checkOutput("rst_op_rw",    32'(op_rw),    32'd1);
    checkOutput("rst_op_uds_n", 32'(op_uds_n), 32'd1);
    checkOutput("rst_op_lds_n", 32'(op_lds_n), 32'd1);
    checkOutput("rst_op_addr",  32'(op_addr),  32'd0);
    checkOutput("rst_op_wdata", 32'(op_wdata), 32'd0);
    checkOutput("rst_pi_rdata", 32'(pi_rdata), 32'd0);
    checkOutput("rst_txn",      32'(txn_in_progress), 32'd0);
    checkOutput("rst_q_full",   32'(q_full),   32'd0);
    rst = 1'b0;
    @(negedge c200m);
    checkRead("rst_status", 2'd3, 16'h2000);

    // Word write
    $display("[TB] word write");
    applyStimulus(24'h001234, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    waitReq(2);
    checkOutput("txn_word_write", 32'(txn_in_progress), POSTED ? 32'd0 : 32'd1);
    serveCmd(16'h0000);
    checkOutput("txn_after_write", 32'(txn_in_progress), 32'd0);
    checkOutput("req_idle_after_write", 32'(op_req), 32'd0);

    // Byte read at an odd address
    $display("[TB] byte read odd address");
    applyStimulus(24'h000001, 16'h0000, 1'b1, 1'b1, 1'b1);
    waitReq(2);
    checkOutput("txn_byte_read", 32'(txn_in_progress), 32'd1);
    serveCmd(16'h00A5);
    checkRead("data_read_a5", 2'd0, 16'h00A5);

    // Byte write at an even address with high address bits
    applyStimulus(24'h123456, 16'h5A5A, 1'b1, 1'b0, 1'b1);
    serveCmd(16'hFFFF);
    checkRead("data_kept_after_write", 2'd0, 16'h00A5);
    checkRead("addr_lo_reads_zero", 2'd1, 16'h0000);
    checkRead("addr_hi_reads_zero", 2'd2, 16'h0000);

    // Fill and overflow with the sequencer stalled
    $display("[TB] fill and overflow");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(24'h010000 + 24'(2 * i), 16'h1000 + 16'(i), 1'b0, 1'b0, i < 5);
    end
    checkOutput("fill_q_full", 32'(q_full), 32'd1);
    checkOutput("fill_txn", 32'(txn_in_progress), 32'd1);
    checkOutput("fill_req", 32'(op_req), 32'd1);
    checkRead("status_overflow", 2'd3, 16'hD400);
    checkRead("status_overflow_cleared", 2'd3, 16'h5400);

    // Combined ack/done in REQ, then push and pop on the same edge while full
    $display("[TB] simultaneous events");
    piWrite(2'd1, 16'h0100);
    piWrite(2'd0, 16'h2222);
    opQueue.push_back(modelCmd(24'h020100, 16'h2222, 1'b0, 1'b0));
    op_ack  = 1'b1;
    op_done = 1'b1;
    @(negedge c200m);
    op_ack  = 1'b0;
    op_done = 1'b0;
    checkOutput("ackdone_to_idle_req", 32'(op_req), 32'd0);
    pi_a      = 2'd2;
    pi_wdata  = 16'h0002;
    pi_wr_stb = 1'b1;
    @(negedge c200m);
    pi_wr_stb = 1'b0;
    checkOutput("pushpop_q_full", 32'(q_full), 32'd1);
    checkOutput("pushpop_reissue", 32'(op_req), 32'd1);
    checkRead("status_pushpop", 2'd3, 16'h5400);

    // Reset during WAIT with two entries still queued
    $display("[TB] reset during wait");
    serveCmd(16'h0000);
    serveCmd(16'h0000);
    waitReq(4);
    op_ack = 1'b1;
    @(negedge c200m);
    op_ack = 1'b0;
    checkRead("status_wait_two_queued", 2'd3, 16'h1200);
    rst = 1'b1;
    @(negedge c200m);
    rst = 1'b0;
    opQueue.delete();
    checkOutput("rstwait_op_req", 32'(op_req), 32'd0);
    checkOutput("rstwait_txn", 32'(txn_in_progress), 32'd0);
    checkOutput("rstwait_q_full", 32'(q_full), 32'd0);
    checkRead("rstwait_status", 2'd3, 16'h2000);
    op_done  = 1'b1;
    op_rdata = 16'hDEAD;
    @(negedge c200m);
    op_done = 1'b0;
    checkOutput("late_done_req", 32'(op_req), 32'd0);
    checkRead("late_done_status", 2'd3, 16'h2000);
    checkRead("late_done_data", 2'd0, 16'h0000);

    // Normal operation resumes: byte read at an even address
    applyStimulus(24'hFFFFFE, 16'h8001, 1'b1, 1'b1, 1'b1);
    serveCmd(16'h1234);
    checkRead("data_read_after_reset", 2'd0, 16'h1234);
    checkOutput("scoreboard_drained", 32'(opQueue.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
